// File: rtl/bramsd_arbiter.sv
// Round-robin read/write arbiter in front of a semi-dual-port block RAM.
// Define BRAMSD_ARBITER_FWD_EN to forward colliding write data instead of stalling the read.
module bramsd_arbiter #(
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned ADDR_ = 8,
  parameter int unsigned DATA_ = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD-1:0]       rd_valid,
  input  logic [NRD*ADDR_-1:0] rd_addr,
  output logic [NRD-1:0]       rd_ready,
  output logic [NRD-1:0]       rsp_valid,
  output logic [DATA_-1:0]     rsp_data,
  input  logic [NWR-1:0]       wr_valid,
  input  logic [NWR*ADDR_-1:0] wr_addr,
  input  logic [NWR*DATA_-1:0] wr_data,
  output logic [NWR-1:0]       wr_ready,
  output logic                 ram_we,
  output logic [ADDR_-1:0]     ram_waddr,
  output logic [DATA_-1:0]     ram_din,
  output logic [ADDR_-1:0]     ram_raddr,
  input  logic [DATA_-1:0]     ram_dout
);

  localparam int unsigned RPW = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int unsigned WPW = (NWR > 1) ? $clog2(NWR) : 1;

  logic [RPW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WPW-1:0]   wr_ptr_q, wr_ptr_d;
  logic             s1_v_q;
  logic [NRD-1:0]   s1_oh_q;
  logic [NRD-1:0]   rsp_valid_q;
  logic [DATA_-1:0] rsp_data_q;

  logic             w_found, r_found;
  logic [NWR-1:0]   w_oh;
  logic [NRD-1:0]   r_oh;
  logic [WPW-1:0]   w_nxt;
  logic [RPW-1:0]   r_nxt;
  logic [ADDR_-1:0] w_addr, r_addr;
  logic [DATA_-1:0] w_dat;
  int unsigned      w_dist, w_best, r_dist, r_best;
  logic             wr_go, rd_go, collide, rd_stall;

  // Winner is the requester at the smallest rotational distance from the pointer.
  always_comb begin
    w_found = 1'b0;
    w_oh    = '0;
    w_nxt   = '0;
    w_addr  = '0;
    w_dat   = '0;
    w_dist  = 0;
    w_best  = NWR;
    for (int unsigned i = 0; i < NWR; i++) begin
      w_dist = (i >= 32'(wr_ptr_q)) ? (i - 32'(wr_ptr_q)) : (i + NWR - 32'(wr_ptr_q));
      if (wr_valid[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_found = 1'b1;
        w_oh    = '0;
        w_oh[i] = 1'b1;
        w_nxt   = (i + 1 == NWR) ? '0 : WPW'(i + 1);
        w_addr  = wr_addr[i*ADDR_ +: ADDR_];
        w_dat   = wr_data[i*DATA_ +: DATA_];
      end
    end
  end

  always_comb begin
    r_found = 1'b0;
    r_oh    = '0;
    r_nxt   = '0;
    r_addr  = '0;
    r_dist  = 0;
    r_best  = NRD;
    for (int unsigned i = 0; i < NRD; i++) begin
      r_dist = (i >= 32'(rd_ptr_q)) ? (i - 32'(rd_ptr_q)) : (i + NRD - 32'(rd_ptr_q));
      if (rd_valid[i] && (r_dist < r_best)) begin
        r_best  = r_dist;
        r_found = 1'b1;
        r_oh    = '0;
        r_oh[i] = 1'b1;
        r_nxt   = (i + 1 == NRD) ? '0 : RPW'(i + 1);
        r_addr  = rd_addr[i*ADDR_ +: ADDR_];
      end
    end
  end

  assign wr_go   = rst_n && w_found;
  assign collide = wr_go && r_found && (r_addr == w_addr);

`ifdef BRAMSD_ARBITER_FWD_EN
  assign rd_stall = 1'b0;
`else
  // Mixed-port read-during-write is undefined in the RAM: hold the read a cycle.
  assign rd_stall = collide;
`endif

  assign rd_go = rst_n && r_found && !rd_stall;

  always_comb begin
    wr_ready  = wr_go ? w_oh : '0;
    ram_we    = wr_go;
    ram_waddr = wr_go ? w_addr : '0;
    ram_din   = wr_go ? w_dat : '0;
    rd_ready  = rd_go ? r_oh : '0;
    ram_raddr = (rst_n && r_found) ? r_addr : '0;
    rd_ptr_d  = rd_go ? r_nxt : rd_ptr_q;
    wr_ptr_d  = wr_go ? w_nxt : wr_ptr_q;
  end

`ifdef BRAMSD_ARBITER_FWD_EN
  logic             s1_fwd_q;
  logic [DATA_-1:0] s1_fdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_fwd_q   <= 1'b0;
      s1_fdata_q <= '0;
    end else begin
      s1_fwd_q   <= rd_go && collide;
      s1_fdata_q <= w_dat;
    end
  end
`endif

  // rsp_valid_q is the second tag stage; rsp_data_q lines up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_oh_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      s1_v_q      <= rd_go;
      s1_oh_q     <= r_oh;
      rsp_valid_q <= s1_v_q ? s1_oh_q : '0;
`ifdef BRAMSD_ARBITER_FWD_EN
      rsp_data_q  <= s1_fwd_q ? s1_fdata_q : ram_dout;
`else
      rsp_data_q  <= ram_dout;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bramsd_arbiter.sv
// Self-checking bench for bramsd_arbiter: directed steps plus random traffic against a
// behavioural model (round-robin by modular search, memory shadow, expected-response queue).
module tb_bramsd_arbiter;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam int unsigned A   = 8;
  localparam int unsigned D   = 8;
`ifdef BRAMSD_ARBITER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [NRD-1:0] rd_valid;
  logic [NRD*A-1:0] rd_addr;
  logic [NRD-1:0] rd_ready;
  logic [NRD-1:0] rsp_valid;
  logic [D-1:0]   rsp_data;
  logic [NWR-1:0] wr_valid;
  logic [NWR*A-1:0] wr_addr;
  logic [NWR*D-1:0] wr_data;
  logic [NWR-1:0] wr_ready;
  logic           ram_we;
  logic [A-1:0]   ram_waddr;
  logic [D-1:0]   ram_din;
  logic [A-1:0]   ram_raddr;
  logic [D-1:0]   ram_dout;

  bramsd_arbiter #(.NRD(NRD), .NWR(NWR), .ADDR_(A), .DATA_(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [D-1:0] init_val(input logic [A-1:0] a);
    return a ^ 8'hB5;
  endfunction

  // RAM: one write port, registered read; unwritten words hold init_val.
  logic [D-1:0] ram [256];
  bit           written [256];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr]     <= ram_din;
      written[ram_waddr] <= 1'b1;
    end
    ram_dout <= written[ram_raddr] ? ram[ram_raddr] : init_val(ram_raddr);
  end

  typedef struct {
    int           cyc;
    int           cl;
    logic [D-1:0] data;
  } rsp_t;

  rsp_t         expq[$];
  logic [D-1:0] ref_mem [256];
  int unsigned  m_rptr, m_wptr;
  int           cyc;
  bit           primed, after_rst;
  int           checks, errors;
  int           n_dut_rd, n_dut_wr, n_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [7:0] v, input int unsigned ptr, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return int'((ptr + k) % n);
    end
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [NRD-1:0] rv, input logic [NRD*A-1:0] ra,
                      input logic [NWR-1:0] wv, input logic [NWR*A-1:0] wa,
                      input logic [NWR*D-1:0] wd);
    int           w, c;
    logic [A-1:0] wad, rad;
    logic [D-1:0] wdat;
    bit           col, acc;
    @(negedge clk);
    rst_n = rst; rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
    if (primed) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << expq[0].cl);
        chk("rsp_data", 32'(rsp_data), 32'(expq[0].data));
        void'(expq.pop_front());
      end else begin
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
      if (after_rst) chk("rsp_data_after_reset", 32'(rsp_data), 32'd0);
    end
    if (!rst) begin
      chk("rd_ready_in_reset", 32'(rd_ready), 32'd0);
      chk("wr_ready_in_reset", 32'(wr_ready), 32'd0);
      chk("ram_we_in_reset", 32'(ram_we), 32'd0);
      expq.delete();
      m_rptr = 0; m_wptr = 0;
      primed = 1'b1; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      w = rr_pick(8'(wv), m_wptr, NWR);
      c = rr_pick(8'(rv), m_rptr, NRD);
      wad = '0; wdat = '0; rad = '0;
      if (w >= 0) begin wad = wa[w*A +: A]; wdat = wd[w*D +: D]; end
      if (c >= 0) rad = ra[c*A +: A];
      col = (w >= 0) && (c >= 0) && (rad == wad);
      acc = (c >= 0) && (FWD || !col);
      chk("wr_ready", 32'(wr_ready), (w >= 0) ? (32'(1) << w) : 32'd0);
      chk("ram_we", 32'(ram_we), 32'(w >= 0));
      chk("ram_waddr", 32'(ram_waddr), 32'(wad));
      chk("ram_din", 32'(ram_din), 32'(wdat));
      chk("rd_ready", 32'(rd_ready), acc ? (32'(1) << c) : 32'd0);
      chk("ram_raddr", 32'(ram_raddr), 32'(rad));
      if (|(rd_valid & rd_ready)) n_dut_rd++;
      if (|(wr_valid & wr_ready)) n_dut_wr++;
      if (rd_valid != '0 && rd_ready == '0) n_stall++;
      if (acc) begin
        expq.push_back('{cyc: cyc + 2, cl: c, data: (FWD && col) ? wdat : ref_mem[rad]});
        m_rptr = (m_rptr == 0 && c < 0) ? 0 : (int'(c) + 1) % NRD;
      end
      if (w >= 0) begin
        ref_mem[wad] = wdat;
        m_wptr = (w + 1) % NWR;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NRD-1:0]   rv_r;
    logic [NRD*A-1:0] ra_r;
    logic [NWR-1:0]   wv_r;
    logic [NWR*A-1:0] wa_r;
    logic [NWR*D-1:0] wd_r;
    int               rd0, wr0, st0;
    checks = 0; errors = 0; cyc = 0; primed = 1'b0; after_rst = 1'b0;
    n_dut_rd = 0; n_dut_wr = 0; n_stall = 0; m_rptr = 0; m_wptr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    rst_n = 1'b0; rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;

    // Reset with requests present: grants must stay low.
    step(1'b0, 2'b11, {8'h02, 8'h01}, 2'b11, {8'h21, 8'h20}, {8'h22, 8'h11});
    step(1'b0, 2'b11, {8'h02, 8'h01}, 2'b11, {8'h21, 8'h20}, {8'h22, 8'h11});

    // Single read of 0x10 (holds 0xA5).
    step(1'b1, 2'b01, {8'h00, 8'h10}, '0, '0, '0);
    idle(2);

    // Read round-robin from pointer 0.
    step(1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, {8'h02, 8'h01}, '0, '0, '0);
    idle(2);

    // Write round-robin then readback.
    step(1'b1, '0, '0, 2'b11, {8'h21, 8'h20}, {8'h22, 8'h11});
    step(1'b1, '0, '0, 2'b11, {8'h21, 8'h20}, {8'h22, 8'h11});
    step(1'b1, 2'b01, {8'h00, 8'h20}, '0, '0, '0);
    step(1'b1, 2'b01, {8'h00, 8'h21}, '0, '0, '0);
    idle(2);

    // Same-address collision.
    step(1'b1, 2'b01, {8'h00, 8'h30}, 2'b01, {8'h00, 8'h30}, {8'h00, 8'h5A});
    step(1'b1, 2'b01, {8'h00, 8'h30}, '0, '0, '0);
    idle(3);

    // Reset in flight: the accepted read must not respond; pointers back to 0.
    step(1'b1, 2'b10, {8'h44, 8'h00}, 2'b10, {8'h55, 8'h00}, {8'h66, 8'h00});
    step(1'b0, '0, '0, '0, '0, '0);
    step(1'b1, 2'b11, {8'h02, 8'h01}, 2'b11, {8'h61, 8'h60}, {8'h01, 8'h02});
    idle(2);

    // Concurrent traffic to disjoint address ranges: no stalls.
    rd0 = n_dut_rd; wr0 = n_dut_wr; st0 = n_stall;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'b11, {8'(8'h48 + k), 8'(8'h40 + k)},
           2'b11, {8'(8'h98 + k), 8'(8'h80 + k)}, {8'(k * 3), 8'(k * 5)});
    end
    idle(2);
    chk("conc_reads", 32'(n_dut_rd - rd0), 32'd16);
    chk("conc_writes", 32'(n_dut_wr - wr0), 32'd16);
    chk("conc_stalls", 32'(n_stall - st0), 32'd0);

    // Random traffic over a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rv_r = NRD'($urandom);
      wv_r = NWR'($urandom);
      for (int k = 0; k < int'(NRD); k++) ra_r[k*A +: A] = A'($urandom_range(0, 7));
      for (int k = 0; k < int'(NWR); k++) begin
        wa_r[k*A +: A] = A'($urandom_range(0, 7));
        wd_r[k*D +: D] = D'($urandom);
      end
      step(($urandom_range(0, 63) != 0), rv_r, ra_r, wv_r, wa_r, wd_r);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
